data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-side responder for the pipeline's MEM-stage data access. It accepts one load/store request at a time over a valid/ready handshake and performs a word write or read on an internal word array. After an optional fixed wait-state delay it returns a single-cycle response. It drives a stall signal that the hazard logic uses to hold PC, IF/ID and the MEM stage while an access is outstanding.

## Interface
Parameters:
- DEPTH, 256: number of 32-bit words; must be a power of two, 4..65536.
- LATENCY, 2: wait cycles inserted before the response, 1..15. Used only when DMEM_WAIT_EN is defined.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  a request is present.
- req_write  in  1  1 = store word, 0 = load word.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_ready  out  1  the block can accept a request this cycle.
- rsp_valid  out  1  one-cycle pulse; the response is valid.
- rsp_rdata  out  32  load data; 0 for stores and for errors.
- rsp_err  out  1  misaligned or out-of-range access; qualified by rsp_valid.
- stall  out  1  hold request for the pipeline.

## Operation
- Address decode:
  - word index = req_addr[log2(DEPTH)+1:2].
  - Misaligned when req_addr[1:0] != 0.
  - Out of range when any req_addr bit above log2(DEPTH)+1 is 1.
  - Either condition is an error.
- FSM states:
  - IDLE: req_ready=1. On req_valid, the request is accepted at the edge. The block latches write, index, wdata and the error flag, then moves to WAIT (macro defined) or RESP (macro undefined).
  - WAIT: counter loaded with LATENCY-1 at acceptance. It decrements each cycle; at count 0 the FSM moves to RESP on the next edge.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- Access action, on the edge that enters RESP:
  - Write without error: the array word is updated; rsp_rdata=0.
  - Read without error: rsp_rdata = array[index].
  - Error: no array update; rsp_rdata=0; rsp_err=1.
- rsp_rdata and rsp_err hold their values until the next entry to RESP.
- req_ready is 0 in WAIT and RESP. Requests presented in those states are ignored; the requester keeps req_valid asserted and holds the payload.
- stall = req_valid & ~rsp_valid, combinational. The MEM stage advances in the rsp_valid cycle.
- The array is not cleared by reset. Its contents are undefined until written.

## Timing
- Reset values: FSM=IDLE, counter=0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, stall=req_valid.
- Reset asserted mid-operation: all of the above take effect immediately. A pending store is discarded and the array is untouched.
- Latency (acceptance edge E0 to rsp_valid cycle):
  - Macro defined: rsp_valid is high between edges E0+LATENCY and E0+LATENCY+1.
  - Macro undefined: rsp_valid is high between E0 and E0+1.
- Throughput: one request per LATENCY+2 cycles (macro defined) or per 2 cycles (macro undefined). The earliest next acceptance is the edge that leaves RESP+1, i.e. from IDLE.
- Read-after-write to the same word on consecutive requests returns the new data.
- A req_valid that drops before acceptance aborts nothing; no state changes.

## Configuration
- DMEM_WAIT_EN defined: the WAIT state and 4-bit counter are compiled in; the response comes LATENCY cycles after acceptance.
- DMEM_WAIT_EN undefined: WAIT and the counter are removed; LATENCY is ignored; the response comes the cycle after acceptance.

## Test plan
- Reset release with req_valid=0: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, stall=0.
- Store 0xDEADBEEF to 0x10, then load 0x10, with DMEM_WAIT_EN and LATENCY=2:
  - Each rsp_valid arrives 2 cycles after acceptance.
  - The load returns 0xDEADBEEF with rsp_err=0.
  - stall is high from req_valid until the rsp_valid cycle.
- Load 0x12, then store to 0x400 with DEPTH=256:
  - Both give rsp_err=1 and rsp_rdata=0.
  - A subsequent load of 0x0 shows unchanged contents.
- Request held during WAIT: req_ready=0 and no second acceptance. After RESP it is accepted from IDLE, at 4-cycle spacing for LATENCY=2.
- Reset asserted in WAIT during a store of 0x12345678 to 0x20: outputs go to reset values at once. A later load of 0x20 returns the prior value.
- Build without DMEM_WAIT_EN: store then load of 0x4 gives rsp_valid one cycle after each acceptance and read data 0x00000055 after storing 0x55.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: MEM-stage data memory responder.
// Accepts one load/store at a time (valid/ready), accesses a word array and
// returns a one-cycle response. stall holds the pipeline while an access is open.
// Optional wait states are enabled by defining DMEM_WAIT_EN; LATENCY then sets
// the number of cycles from acceptance to response.
module data_mem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Elaboration-time parameter range checks
  if ((DEPTH < 4) || (DEPTH > 65536) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("data_mem_responder: DEPTH must be a power of two in 4..65536");
  end
  if ((LATENCY < 1) || (LATENCY > 15)) begin : g_bad_latency
    $error("data_mem_responder: LATENCY must be in 1..15");
  end

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RESP = 2'd2;
`ifdef DMEM_WAIT_EN
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
`endif

  logic [31:0]   r_mem [DEPTH];
  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [31:0]   r_rdata;
  logic          r_rsp_err;

  logic          w_misaligned;
  logic          w_out_of_range;
  logic          w_req_err;
  logic          w_accept;
  logic          w_enter_resp;

  // Fields used by the access performed on the edge that enters RESP
  logic          w_acc_write;
  logic [AW-1:0] w_acc_index;
  logic [31:0]   w_acc_wdata;
  logic          w_acc_err;

  assign w_misaligned   = |req_addr[1:0];
  assign w_out_of_range = |req_addr[31:AW+2];
  assign w_req_err      = w_misaligned | w_out_of_range;
  // reset gates acceptance so a request held during reset never reaches the array
  assign w_accept       = reset & (r_state == S_IDLE) & req_valid;

`ifdef DMEM_WAIT_EN
  logic          r_write;
  logic [AW-1:0] r_index;
  logic [31:0]   r_wdata;
  logic          r_err;
  logic [3:0]    r_cnt;

  // Latch the request payload at acceptance
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_write <= 1'b0;
      r_index <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_write <= req_write;
      r_index <= req_addr[AW+1:2];
      r_wdata <= req_wdata;
      r_err   <= w_req_err;
    end
  end

  // Wait-state counter: loaded at acceptance, counts down in WAIT
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= LAT_M1;
    end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign w_enter_resp = reset & (r_state == S_WAIT) & (r_cnt == '0);
  assign w_acc_write  = r_write;
  assign w_acc_index  = r_index;
  assign w_acc_wdata  = r_wdata;
  assign w_acc_err    = r_err;

  // Next-state logic with wait states
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_WAIT;
      S_WAIT:  if (r_cnt == '0) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end
`else
  // Without wait states the access happens on the acceptance edge itself,
  // so it uses the live request fields instead of a latched copy.
  assign w_enter_resp = w_accept;
  assign w_acc_write  = req_write;
  assign w_acc_index  = req_addr[AW+1:2];
  assign w_acc_wdata  = req_wdata;
  assign w_acc_err    = w_req_err;

  // Next-state logic without wait states
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end
`endif

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Word array: not reset; written only by an error-free store entering RESP
  always_ff @(posedge clock) begin
    if (w_enter_resp && w_acc_write && !w_acc_err) begin
      r_mem[w_acc_index] <= w_acc_wdata;
    end
  end

  // Response data/error, held until the next entry to RESP
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rdata   <= '0;
      r_rsp_err <= 1'b0;
    end else if (w_enter_resp) begin
      r_rdata   <= (!w_acc_write && !w_acc_err) ? r_mem[w_acc_index] : '0;
      r_rsp_err <= w_acc_err;
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_rsp_err;
  assign stall     = req_valid & ~rsp_valid;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder (DEPTH=256, LATENCY=2).
// Expected response timing follows DMEM_WAIT_EN as seen by this file.
module tb_data_mem_responder;

  localparam int unsigned DEPTH   = 256;
  localparam int unsigned LATENCY = 2;
`ifdef DMEM_WAIT_EN
  localparam int LAT_EDGES = LATENCY;
`else
  localparam int LAT_EDGES = 0;
`endif
  localparam int TIMEOUT = 20;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;

  int checks = 0;
  int errors = 0;

  data_mem_responder #(
    .DEPTH  (DEPTH),
    .LATENCY(LATENCY)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .stall    (stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000 time units");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One full transaction from IDLE: present, accept, wait for response, release.
  task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err);
    int k;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    #1;
    check({tag, " ready_idle"}, 32'(req_ready), 32'd1);
    check({tag, " stall_pending"}, 32'(stall), 32'd1);
    step();
    k = 0;
    while (!rsp_valid && k < TIMEOUT) begin
      check({tag, " ready_busy"}, 32'(req_ready), 32'd0);
      check({tag, " stall_busy"}, 32'(stall), 32'd1);
      step();
      k++;
    end
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, " latency"}, 32'(k), 32'(LAT_EDGES));
    check({tag, " rdata"}, rsp_rdata, exp_rdata);
    check({tag, " err"}, 32'(rsp_err), 32'(exp_err));
    check({tag, " stall_rsp"}, 32'(stall), 32'd0);
    req_valid = 1'b0;
    step();
    check({tag, " rsp_pulse"}, 32'(rsp_valid), 32'd0);
    check({tag, " ready_after"}, 32'(req_ready), 32'd1);
    check({tag, " rdata_hold"}, rsp_rdata, exp_rdata);
    check({tag, " err_hold"}, 32'(rsp_err), 32'(exp_err));
  endtask

  initial begin
    int k;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;

    // Reset state
    step();
    step();
    check("rst ready", 32'(req_ready), 32'd1);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    #2 reset = 1'b1;
    step();
    check("rel ready", 32'(req_ready), 32'd1);
    check("rel rsp_valid", 32'(rsp_valid), 32'd0);
    check("rel rdata", rsp_rdata, 32'h0);
    check("rel err", 32'(rsp_err), 32'd0);
    check("rel stall", 32'(stall), 32'd0);

    // Store then load, read-after-write
    do_req("st10", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    do_req("ld10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Errors: misaligned load, out-of-range store that would alias word 0
    do_req("st00", 1'b1, 32'h0, 32'hA5A5A5A5, 32'h0, 1'b0);
    do_req("ld12", 1'b0, 32'h12, 32'h0, 32'h0, 1'b1);
    do_req("st400", 1'b1, 32'h400, 32'hFFFFFFFF, 32'h0, 1'b1);
    do_req("ld00", 1'b0, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0);
    do_req("ld3fc_oor", 1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b1);

    // Request held across RESP: re-accepted from IDLE at LATENCY+2 spacing
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h10;
    req_wdata = '0;
    k = 0;
    while (!rsp_valid && k < TIMEOUT) begin
      step();
      k++;
    end
    check("hold first rsp", 32'(rsp_valid), 32'd1);
    check("hold first rdata", rsp_rdata, 32'hDEADBEEF);
    step();
    check("hold ready_after_rsp", 32'(req_ready), 32'd1);
    check("hold stall_idle", 32'(stall), 32'd1);
    k = 1;
    while (!rsp_valid && k < TIMEOUT) begin
      step();
      k++;
    end
    check("hold second rsp", 32'(rsp_valid), 32'd1);
    check("hold spacing", 32'(k), 32'(LAT_EDGES + 2));
    check("hold second rdata", rsp_rdata, 32'hDEADBEEF);
    req_valid = 1'b0;
    step();

    // Reset during an in-flight store: store discarded, outputs cleared at once
    do_req("st20", 1'b1, 32'h20, 32'h11111111, 32'h0, 1'b0);
    do_req("ld20a", 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h12345678;
`ifdef DMEM_WAIT_EN
    step();
    check("mid ready_wait", 32'(req_ready), 32'd0);
`endif
    #2 reset = 1'b0;
    #1;
    check("mid ready", 32'(req_ready), 32'd1);
    check("mid rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid rdata", rsp_rdata, 32'h0);
    check("mid err", 32'(rsp_err), 32'd0);
    check("mid stall", 32'(stall), 32'd1);
    step();
    req_valid = 1'b0;
    step();
    #2 reset = 1'b1;
    step();
    check("mid rel ready", 32'(req_ready), 32'd1);
    do_req("ld20b", 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0);

    // Store then load of a small value at 0x4
    do_req("st04", 1'b1, 32'h4, 32'h55, 32'h0, 1'b0);
    do_req("ld04", 1'b0, 32'h4, 32'h0, 32'h00000055, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
